// File: rtl/lynx48_adc_pkg.sv
// Shared definitions for the LTC2308 sequencer: FSM states, bit count and
// the per-channel ADC configuration word.
package lynx48_adc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CONV  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int unsigned ADC_BITS = 12;

  // Single-ended, unipolar, awake: {S/D, O/S, S1, S0, UNI, SLP}
  function automatic logic [5:0] cfg_word(input logic [2:0] c);
    return {1'b1, c[0], c[2], c[1], 1'b1, 1'b0};
  endfunction

endpackage

// File: rtl/tape_comparator.sv
// Hysteresis comparator turning tape-channel samples into the EAR bit, plus
// an activity counter that keeps tape_active up while the level keeps toggling.
module tape_comparator #(
  parameter logic [11:0] TAPE_HI     = 12'h900,
  parameter logic [11:0] TAPE_LO     = 12'h700,
  parameter int unsigned ACT_SAMPLES = 4096
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        valid,
  input  logic [11:0] data,
  output logic        level,
  output logic        active
);

  localparam int unsigned CW = $clog2(ACT_SAMPLES + 1);

  logic          level_q, level_d;
  logic [CW-1:0] act_q, act_d;

  always_comb begin
    level_d = level_q;
    act_d   = act_q;
    if (valid) begin
      if (data > TAPE_HI)      level_d = 1'b1;
      else if (data < TAPE_LO) level_d = 1'b0;
      if (level_d != level_q)  act_d = CW'(ACT_SAMPLES);
      else if (act_q != '0)    act_d = act_q - CW'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      level_q <= 1'b0;
      act_q   <= '0;
    end else begin
      level_q <= level_d;
      act_q   <= act_d;
    end
  end

  assign level  = level_q;
  assign active = (act_q != '0);

endmodule

// File: rtl/ltc2308_sequencer.sv
// Periodic LTC2308 conversion scheduler: round-robins enabled channels, tags
// each 12-bit result with its channel and feeds the tape comparator.
module ltc2308_sequencer
  import lynx48_adc_pkg::*;
#(
  parameter int unsigned SCK_DIV     = 2,
  parameter int unsigned CONV_CYCLES = 84,
  parameter int unsigned SAMPLE_DIV  = 1250,
  parameter logic [2:0]  TAPE_CH     = 3'd0,
  parameter logic [11:0] TAPE_HI     = 12'h900,
  parameter logic [11:0] TAPE_LO     = 12'h700,
  parameter int unsigned ACT_SAMPLES = 4096
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [7:0]  ch_mask,
  output logic        adc_convst,
  output logic        adc_sck,
  output logic        adc_sdi,
  input  logic        adc_sdo,
  output logic        sample_valid,
  output logic [11:0] sample_data,
  output logic [2:0]  sample_ch,
  output logic        tape_level,
  output logic        tape_active,
  output logic        overrun,
  output state_e      dbg_state
);

  localparam int unsigned TW = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [15:0]   CONV_LAST = 16'(CONV_CYCLES - 1);
  localparam logic [15:0]   SCK_HALF  = 16'(SCK_DIV);
  localparam logic [15:0]   BIT_LAST  = 16'(2 * SCK_DIV - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [3:0]    bit_q, bit_d;
  logic [2:0]    ch_q, ch_d;
  logic [2:0]    res_ch_q, res_ch_d;
  logic [10:0]   shift_q, shift_d;
  logic          discard_q, discard_d;
  logic          valid_q, valid_d;
  logic [11:0]   data_q, data_d;
  logic [2:0]    sch_q, sch_d;
  logic          overrun_q, overrun_d;

  logic       tick;
  logic [7:0] mask_eff;
  logic [2:0] next_ch, idx;
  logic       found;
  logic [5:0] cfg_cur;

  // Next enabled channel strictly after ch_q; an all-zero mask means channel 0.
  always_comb begin
    mask_eff = (ch_mask == 8'h00) ? 8'h01 : ch_mask;
    next_ch  = ch_q;
    idx      = ch_q;
    found    = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      idx = ch_q + 3'(i);
      if (!found && mask_eff[idx]) begin
        next_ch = idx;
        found   = 1'b1;
      end
    end
  end

  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TW'(1);
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    ch_d       = ch_q;
    res_ch_d   = res_ch_q;
    shift_d    = shift_q;
    discard_d  = discard_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    sch_d      = sch_q;
    overrun_d  = overrun_q | (tick && state_q != IDLE);
    case (state_q)
      IDLE: if (tick) begin
        state_d  = CONV;
        cnt_d    = '0;
        ch_d     = next_ch;
        res_ch_d = ch_q;
      end
      CONV: if (cnt_q == CONV_LAST) begin
        state_d = SHIFT;
        cnt_d   = '0;
        bit_d   = '0;
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      SHIFT: if (cnt_q == BIT_LAST) begin
        shift_d = {shift_q[9:0], adc_sdo};
        cnt_d   = '0;
        if (bit_q == 4'(ADC_BITS - 1)) begin
          state_d = DONE;
          // The result of the first frame after reset comes from an unknown config.
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            valid_d = 1'b1;
            data_d  = {shift_q, adc_sdo};
            sch_d   = res_ch_q;
          end
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end else begin
        cnt_d = cnt_q + 16'd1;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      cnt_q      <= '0;
      bit_q      <= '0;
      ch_q       <= 3'd7;
      res_ch_q   <= '0;
      shift_q    <= '0;
      discard_q  <= 1'b1;
      valid_q    <= 1'b0;
      data_q     <= '0;
      sch_q      <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      ch_q       <= ch_d;
      res_ch_q   <= res_ch_d;
      shift_q    <= shift_d;
      discard_q  <= discard_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      sch_q      <= sch_d;
      overrun_q  <= overrun_d;
    end
  end

  // ADC pins are pure decodes of the registered state, so reset idles them at once.
  always_comb begin
    cfg_cur    = cfg_word(ch_q);
    adc_convst = (state_q == CONV) && (cnt_q < 16'd2);
    adc_sck    = (state_q == SHIFT) && (cnt_q >= SCK_HALF);
    adc_sdi    = 1'b0;
    if (state_q == SHIFT) begin
      case (bit_q)
        4'd0:    adc_sdi = cfg_cur[5];
        4'd1:    adc_sdi = cfg_cur[4];
        4'd2:    adc_sdi = cfg_cur[3];
        4'd3:    adc_sdi = cfg_cur[2];
        4'd4:    adc_sdi = cfg_cur[1];
        4'd5:    adc_sdi = cfg_cur[0];
        default: adc_sdi = 1'b0;
      endcase
    end
  end

  tape_comparator #(
    .TAPE_HI    (TAPE_HI),
    .TAPE_LO    (TAPE_LO),
    .ACT_SAMPLES(ACT_SAMPLES)
  ) u_tape (
    .clk_sys(clk_sys),
    .reset  (reset),
    .valid  (valid_q && (sch_q == TAPE_CH)),
    .data   (data_q),
    .level  (tape_level),
    .active (tape_active)
  );

  assign sample_valid = valid_q;
  assign sample_data  = data_q;
  assign sample_ch    = sch_q;
  assign overrun      = overrun_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_ltc2308_sequencer.sv
// Directed bench for ltc2308_sequencer with a behavioural LTC2308 model that
// latches the config word on SCK rise and converts with it at the next CONVST.
module tb_ltc2308_sequencer;
  import lynx48_adc_pkg::*;

  // clock / reset
  logic clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;
  logic       reset   = 1'b1;
  logic [7:0] ch_mask = 8'h01;

  logic        adc_convst, adc_sck, adc_sdi, adc_sdo;
  logic        sample_valid, tape_level, tape_active, overrun;
  logic [11:0] sample_data;
  logic [2:0]  sample_ch;
  state_e      dbg_state;

  logic        convst_b, sck_b, sdi_b, valid_b, level_b, active_b, overrun_b;
  logic [11:0] data_b;
  logic [2:0]  ch_b;
  state_e      state_b;

  ltc2308_sequencer #(.ACT_SAMPLES(4)) dut (
    .clk_sys(clk_sys), .reset(reset), .ch_mask(ch_mask),
    .adc_convst(adc_convst), .adc_sck(adc_sck), .adc_sdi(adc_sdi), .adc_sdo(adc_sdo),
    .sample_valid(sample_valid), .sample_data(sample_data), .sample_ch(sample_ch),
    .tape_level(tape_level), .tape_active(tape_active), .overrun(overrun),
    .dbg_state(dbg_state)
  );

  // Tick period shorter than a frame; ADC line stuck high.
  ltc2308_sequencer #(.SAMPLE_DIV(100)) dut_b (
    .clk_sys(clk_sys), .reset(reset), .ch_mask(ch_mask),
    .adc_convst(convst_b), .adc_sck(sck_b), .adc_sdi(sdi_b), .adc_sdo(1'b1),
    .sample_valid(valid_b), .sample_data(data_b), .sample_ch(ch_b),
    .tape_level(level_b), .tape_active(active_b), .overrun(overrun_b),
    .dbg_state(state_b)
  );

  // ADC model
  logic [11:0] fixed_word = 12'hA5C;
  logic        chan_mode  = 1'b0;
  logic [5:0]  cfg_sr     = 6'h00;
  logic [11:0] sdo_sr     = 12'h000;
  logic [5:0]  cfg_log[$];
  int          sck_n      = 0;
  int          sdi_err    = 0;

  function automatic logic [11:0] chan_word(input logic [5:0] cfg);
    logic [2:0] c;
    c = {cfg[3], cfg[2], cfg[4]};
    return {1'b0, c, 8'h5A};
  endfunction

  always @(posedge adc_convst) begin
    sdo_sr = chan_mode ? chan_word(cfg_sr) : fixed_word;
    sck_n  = 0;
  end
  always @(posedge adc_sck) begin
    if (sck_n < 6) cfg_sr = {cfg_sr[4:0], adc_sdi};
    else if (adc_sdi) sdi_err++;
    if (sck_n == 5) cfg_log.push_back(cfg_sr);
    sck_n++;
  end
  always @(negedge adc_sck) sdo_sr = {sdo_sr[10:0], 1'b0};
  assign adc_sdo = sdo_sr[11];

  // monitors
  time conv_rise_t = 0;
  int  conv_rises  = 0;
  int  b_valids    = 0;
  logic convst_prev = 1'b0;
  always @(negedge clk_sys) begin
    if (adc_convst && !convst_prev) begin
      conv_rise_t = $time;
      conv_rises++;
    end
    convst_prev = adc_convst;
    if (valid_b) b_valids++;
  end

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // drivers
  task automatic do_reset();
    @(negedge clk_sys);
    reset = 1'b1;
    repeat (3) @(negedge clk_sys);
    conv_rises = 0;
    b_valids   = 0;
    sdi_err    = 0;
    cfg_log.delete();
    reset = 1'b0;
  endtask

  task automatic wait_valid(output time t_v);
    int n;
    n = 0;
    @(negedge clk_sys);
    while (!sample_valid && n < 3000) begin
      @(negedge clk_sys);
      n++;
    end
    check("valid_seen", sample_valid, 1'b1);
    t_v = $time;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_valid"},   sample_valid, 0);
    check({tag, "_data"},    sample_data, 0);
    check({tag, "_ch"},      sample_ch, 0);
    check({tag, "_level"},   tape_level, 0);
    check({tag, "_active"},  tape_active, 0);
    check({tag, "_overrun"}, overrun, 0);
    check({tag, "_convst"},  adc_convst, 0);
    check({tag, "_sck"},     adc_sck, 0);
    check({tag, "_sdi"},     adc_sdi, 0);
    check({tag, "_state"},   dbg_state, IDLE);
  endtask

  logic [11:0] tape_words [8] = '{12'h800, 12'h950, 12'h800, 12'h6F0,
                                  12'h6F0, 12'h6F0, 12'h6F0, 12'h6F0};
  logic        tape_lvl_x [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  logic        tape_act_x [8] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [5:0]  cfg26_x [4]    = '{6'b110010, 6'b100110, 6'b111010, 6'b110010};
  logic [2:0]  ch26_x [3]     = '{3'd1, 3'd2, 3'd5};

  initial begin
    time t1, t2, tv;
    int  n;
    logic [11:0] got_w;

    // mask 8'h01, fixed result A5C
    ch_mask = 8'h01; chan_mode = 1'b0; fixed_word = 12'hA5C;
    do_reset();
    check_idle_outputs("rst");
    check("rst_overrun_b", overrun_b, 0);
    wait_valid(t1);
    check("first_frame_discarded", conv_rises, 2);
    check("latency", 32'((t1 - conv_rise_t) / 10), 132);
    exp_q.push_back(12'hA5C);
    check("m01_data0", sample_data, exp_q.pop_front());
    check("m01_ch0", sample_ch, 0);
    @(negedge clk_sys);
    check("valid_one_cycle", sample_valid, 0);
    check("data_hold", sample_data, 12'hA5C);
    wait_valid(t2);
    check("period", 32'((t2 - t1) / 10), 1250);
    check("m01_data1", sample_data, 12'hA5C);
    check("m01_ch1", sample_ch, 0);
    check("overrun_b_set", overrun_b, 1);
    check("b_emits_valid", b_valids >= 2, 1);
    check("b_data", data_b, 12'hFFF);
    check("b_ch", ch_b, 0);
    check("overrun_a_clear", overrun, 0);
    repeat (300) @(negedge clk_sys);
    check("overrun_b_sticky", overrun_b, 1);

    // mask 8'h26, result encodes the converted channel
    ch_mask = 8'h26; chan_mode = 1'b1;
    do_reset();
    for (int i = 0; i < 3; i++) exp_q.push_back({1'b0, ch26_x[i], 8'h5A});
    for (int i = 0; i < 3; i++) begin
      wait_valid(tv);
      check($sformatf("m26_data%0d", i), sample_data, exp_q.pop_front());
      check($sformatf("m26_ch%0d", i), sample_ch, ch26_x[i]);
    end
    check("m26_cfg_count", cfg_log.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("m26_cfg%0d", i), (i < cfg_log.size()) ? cfg_log[i] : 6'h3F, cfg26_x[i]);
    check("m26_sdi_tail_zero", sdi_err, 0);

    // mask 0 behaves as channel 0 only
    ch_mask = 8'h00;
    do_reset();
    wait_valid(tv);
    check("m00_data", sample_data, 12'h05A);
    check("m00_ch", sample_ch, 0);
    check("m00_cfg_count", cfg_log.size(), 2);
    for (int i = 0; i < 2; i++)
      check($sformatf("m00_cfg%0d", i), (i < cfg_log.size()) ? cfg_log[i] : 6'h3F, 6'b100010);

    // tape comparator on channel 0
    ch_mask = 8'h01; chan_mode = 1'b0; fixed_word = tape_words[0];
    do_reset();
    for (int i = 0; i < 8; i++) begin
      fixed_word = tape_words[i];
      wait_valid(tv);
      check($sformatf("tape_data%0d", i), sample_data, tape_words[i]);
      if (i == 1) check("tape_level_lag", tape_level, 0);
      @(negedge clk_sys);
      check($sformatf("tape_level%0d", i), tape_level, tape_lvl_x[i]);
      check($sformatf("tape_active%0d", i), tape_active, tape_act_x[i]);
    end

    // reset pulsed during SHIFT of a frame that would emit a sample
    fixed_word = 12'hA5C;
    do_reset();
    wait_valid(tv);
    got_w = sample_data;
    check("pre_reset_data", got_w, 12'hA5C);
    n = 0;
    while (!adc_sck && n < 2000) begin
      @(negedge clk_sys);
      n++;
    end
    check("shift_reached", adc_sck, 1);
    reset = 1'b1;
    @(negedge clk_sys);
    check_idle_outputs("midrst");
    conv_rises = 0;
    reset = 1'b0;
    wait_valid(tv);
    check("midrst_discard", conv_rises, 2);
    check("midrst_data", sample_data, 12'hA5C);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
